// File: rtl/pipe_ctrl_unit_if.sv
// Control-unit bundle between the decoder/datapath side and the pipeline
// control unit. Carries the ID-stage decode fields, the registered zero flag,
// and every per-stage control, forwarding and hazard output.
interface pipe_ctrl_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 2
);
    logic                  id_branch;
    logic                  id_memRead;
    logic                  id_memToReg;
    logic [ALUOP_W-1:0]    id_aluOp;
    logic                  id_memWrite;
    logic                  id_aluSrc;
    logic                  id_regWrite;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  mem_zero;

    logic [ALUOP_W-1:0]    ex_aluOp;
    logic                  ex_aluSrc;
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
    logic                  mem_memRead;
    logic                  mem_memWrite;
    logic                  mem_branch;
    logic                  wb_memToReg;
    logic                  wb_regWrite;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  pcSrc;
    logic                  stall;
    logic                  flush;
    logic [1:0]            forwardA;
    logic [1:0]            forwardB;

    // Decoder/datapath side: supplies ID fields and the zero flag.
    modport master (
        output id_branch, id_memRead, id_memToReg, id_aluOp, id_memWrite,
               id_aluSrc, id_regWrite, id_rs1, id_rs2, id_rd, mem_zero,
        input  ex_aluOp, ex_aluSrc, ex_rs1, ex_rs2, mem_memRead, mem_memWrite,
               mem_branch, wb_memToReg, wb_regWrite, wb_rd, pcSrc, stall,
               flush, forwardA, forwardB
    );

    // Pipeline control unit side.
    modport slave (
        input  id_branch, id_memRead, id_memToReg, id_aluOp, id_memWrite,
               id_aluSrc, id_regWrite, id_rs1, id_rs2, id_rd, mem_zero,
        output ex_aluOp, ex_aluSrc, ex_rs1, ex_rs2, mem_memRead, mem_memWrite,
               mem_branch, wb_memToReg, wb_regWrite, wb_rd, pcSrc, stall,
               flush, forwardA, forwardB
    );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control unit for the 5-stage core. Carries the decoded control
// bundle through ID/EX, EX/MEM and MEM/WB, inserts a bubble on load-use
// hazards, squashes the two younger instructions on a taken beq resolved in
// MEM, and produces the EX-stage operand forwarding selects.
module pipe_ctrl_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 2
) (
    input  logic           clk,
    input  logic           reset,
    pipe_ctrl_unit_if.slave bus
);

    typedef struct packed {
        logic                  branch;
        logic                  mem_read;
        logic                  mem_to_reg;
        logic [ALUOP_W-1:0]    alu_op;
        logic                  mem_write;
        logic                  alu_src;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
    } id_ex_t;

    typedef struct packed {
        logic                  branch;
        logic                  mem_read;
        logic                  mem_to_reg;
        logic                  mem_write;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] rd;
    } ex_mem_t;

    typedef struct packed {
        logic                  mem_to_reg;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] rd;
    } mem_wb_t;

    id_ex_t  id_ex_d,  id_ex_q;
    ex_mem_t ex_mem_d, ex_mem_q;
    mem_wb_t mem_wb_d, mem_wb_q;

    logic       hazard;
    logic       pc_src;
    logic       stall_int;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    // Branch resolution and load-use detection; only registered state plus
    // the ID source indices and the zero flag feed these.
    always_comb begin
        pc_src    = ex_mem_q.branch & bus.mem_zero;
        hazard    = id_ex_q.mem_read & (id_ex_q.rd != '0) &
                    ((id_ex_q.rd == bus.id_rs1) | (id_ex_q.rd == bus.id_rs2));
        stall_int = hazard & ~pc_src;
    end

    // EX operand forwarding: the younger EX/MEM result beats MEM/WB, x0 never forwards.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (ex_mem_q.reg_write && (ex_mem_q.rd != '0) && (ex_mem_q.rd == id_ex_q.rs1)) begin
            fwd_a = 2'b10;
        end else if (mem_wb_q.reg_write && (mem_wb_q.rd != '0) && (mem_wb_q.rd == id_ex_q.rs1)) begin
            fwd_a = 2'b01;
        end
        if (ex_mem_q.reg_write && (ex_mem_q.rd != '0) && (ex_mem_q.rd == id_ex_q.rs2)) begin
            fwd_b = 2'b10;
        end else if (mem_wb_q.reg_write && (mem_wb_q.rd != '0) && (mem_wb_q.rd == id_ex_q.rs2)) begin
            fwd_b = 2'b01;
        end
    end

    // Next pipeline contents: a flush zeroes ID/EX and EX/MEM, a stall zeroes
    // only ID/EX; when both apply the single bubble from the flush covers it.
    always_comb begin
        id_ex_d            = '0;
        id_ex_d.branch     = bus.id_branch;
        id_ex_d.mem_read   = bus.id_memRead;
        id_ex_d.mem_to_reg = bus.id_memToReg & bus.id_regWrite;
        id_ex_d.alu_op     = bus.id_aluOp;
        id_ex_d.mem_write  = bus.id_memWrite;
        id_ex_d.alu_src    = bus.id_aluSrc;
        id_ex_d.reg_write  = bus.id_regWrite;
        id_ex_d.rs1        = bus.id_rs1;
        id_ex_d.rs2        = bus.id_rs2;
        id_ex_d.rd         = bus.id_rd;
        if (pc_src || stall_int) begin
            id_ex_d = '0;
        end

        ex_mem_d            = '0;
        ex_mem_d.branch     = id_ex_q.branch;
        ex_mem_d.mem_read   = id_ex_q.mem_read;
        ex_mem_d.mem_to_reg = id_ex_q.mem_to_reg;
        ex_mem_d.mem_write  = id_ex_q.mem_write;
        ex_mem_d.reg_write  = id_ex_q.reg_write;
        ex_mem_d.rd         = id_ex_q.rd;
        if (pc_src) begin
            ex_mem_d = '0;
        end

        mem_wb_d            = '0;
        mem_wb_d.mem_to_reg = ex_mem_q.mem_to_reg;
        mem_wb_d.reg_write  = ex_mem_q.reg_write;
        mem_wb_d.rd         = ex_mem_q.rd;
    end

    // Pipeline registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    assign bus.ex_aluOp     = id_ex_q.alu_op;
    assign bus.ex_aluSrc    = id_ex_q.alu_src;
    assign bus.ex_rs1       = id_ex_q.rs1;
    assign bus.ex_rs2       = id_ex_q.rs2;
    assign bus.mem_memRead  = ex_mem_q.mem_read;
    assign bus.mem_memWrite = ex_mem_q.mem_write;
    assign bus.mem_branch   = ex_mem_q.branch;
    assign bus.wb_memToReg  = mem_wb_q.mem_to_reg;
    assign bus.wb_regWrite  = mem_wb_q.reg_write;
    assign bus.wb_rd        = mem_wb_q.rd;
    assign bus.pcSrc        = pc_src;
    assign bus.stall        = stall_int;
    assign bus.flush        = pc_src;
    assign bus.forwardA     = fwd_a;
    assign bus.forwardB     = fwd_b;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: directed reset/flush/hazard
// sequences, a hand-derived vector table for hazard and forwarding timing,
// and a scoreboard stream that follows each instruction from ID to WB.
module tb_pipe_ctrl_unit;

    localparam int RW = 5;
    localparam int AW = 2;

    typedef struct packed {
        logic          branch;
        logic          mem_read;
        logic          mem_to_reg;
        logic [AW-1:0] alu_op;
        logic          mem_write;
        logic          alu_src;
        logic          reg_write;
        logic [RW-1:0] rs1;
        logic [RW-1:0] rs2;
        logic [RW-1:0] rd;
    } instr_t;

    typedef struct {
        instr_t     instr;
        logic       mem_zero;
        logic       exp_stall;
        logic       exp_pc_src;
        logic [1:0] exp_fwd_a;
        logic [1:0] exp_fwd_b;
        logic [1:0] exp_ex_alu_op;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   check_count = 0;
    int   error_count = 0;

    vec_t   vec[13];
    instr_t sb_q[$];

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    pipe_ctrl_unit_if #(.REG_ADDR_W(RW), .ALUOP_W(AW)) bus ();

    pipe_ctrl_unit #(.REG_ADDR_W(RW), .ALUOP_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic instr_t make_rtype(input int rs1, input int rs2, input int rd);
        instr_t i;
        i           = '0;
        i.alu_op    = 2'b10;
        i.reg_write = 1'b1;
        i.rs1       = RW'(rs1);
        i.rs2       = RW'(rs2);
        i.rd        = RW'(rd);
        return i;
    endfunction

    function automatic instr_t make_load(input int rs1, input int rd);
        instr_t i;
        i            = '0;
        i.mem_read   = 1'b1;
        i.mem_to_reg = 1'b1;
        i.alu_src    = 1'b1;
        i.reg_write  = 1'b1;
        i.rs1        = RW'(rs1);
        i.rd         = RW'(rd);
        return i;
    endfunction

    function automatic instr_t make_store(input int rs1, input int rs2);
        instr_t i;
        i           = '0;
        i.mem_write = 1'b1;
        i.alu_src   = 1'b1;
        i.rs1       = RW'(rs1);
        i.rs2       = RW'(rs2);
        return i;
    endfunction

    function automatic instr_t make_beq(input int rs1, input int rs2);
        instr_t i;
        i        = '0;
        i.branch = 1'b1;
        i.alu_op = 2'b01;
        i.rs1    = RW'(rs1);
        i.rs2    = RW'(rs2);
        return i;
    endfunction

    function automatic instr_t random_instr();
        instr_t i;
        i            = '0;
        i.mem_to_reg = 1'($urandom_range(0, 1));
        i.alu_op     = 2'($urandom_range(0, 3));
        i.mem_write  = 1'($urandom_range(0, 1));
        i.alu_src    = 1'($urandom_range(0, 1));
        i.reg_write  = 1'($urandom_range(0, 1));
        i.rs1        = 5'($urandom_range(0, 31));
        i.rs2        = 5'($urandom_range(0, 31));
        i.rd         = 5'($urandom_range(0, 31));
        return i;
    endfunction

    function automatic vec_t mk_vec(input instr_t ins, input logic zero, input logic st,
                                    input logic pc, input logic [1:0] fa, input logic [1:0] fb,
                                    input logic [1:0] alu);
        vec_t v;
        v.instr         = ins;
        v.mem_zero      = zero;
        v.exp_stall     = st;
        v.exp_pc_src    = pc;
        v.exp_fwd_a     = fa;
        v.exp_fwd_b     = fb;
        v.exp_ex_alu_op = alu;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input instr_t ins, input logic zero);
        bus.id_branch   = ins.branch;
        bus.id_memRead  = ins.mem_read;
        bus.id_memToReg = ins.mem_to_reg;
        bus.id_aluOp    = ins.alu_op;
        bus.id_memWrite = ins.mem_write;
        bus.id_aluSrc   = ins.alu_src;
        bus.id_regWrite = ins.reg_write;
        bus.id_rs1      = ins.rs1;
        bus.id_rs2      = ins.rs2;
        bus.id_rd       = ins.rd;
        bus.mem_zero    = zero;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check_output(name,
            {2'b0, bus.ex_aluOp, bus.ex_aluSrc, bus.ex_rs1, bus.ex_rs2, bus.mem_memRead,
             bus.mem_memWrite, bus.mem_branch, bus.wb_memToReg, bus.wb_regWrite, bus.wb_rd,
             bus.pcSrc, bus.stall, bus.flush, bus.forwardA, bus.forwardB},
            32'h0);
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) begin
            apply_stimulus('0, 1'b0);
            tick();
        end
    endtask

    // Watchdog so a stuck run still ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        // Rows assume an empty pipe; stage notes give state before the edge.
        vec[0]  = mk_vec(make_load(1, 5),    1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        vec[1]  = mk_vec(make_rtype(5, 2, 6), 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
        vec[2]  = mk_vec(make_rtype(5, 2, 6), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10);
        vec[3]  = mk_vec('0,                 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00);
        vec[4]  = mk_vec(make_load(1, 0),    1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        vec[5]  = mk_vec(make_rtype(0, 3, 8), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10);
        vec[6]  = mk_vec('0,                 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        vec[7]  = mk_vec(make_rtype(1, 2, 7), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10);
        vec[8]  = mk_vec(make_rtype(3, 4, 7), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10);
        vec[9]  = mk_vec(make_rtype(7, 7, 9), 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10);
        vec[10] = mk_vec('0,                 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 2'b00);
        vec[11] = mk_vec(make_rtype(0, 9, 10), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10);
        vec[12] = mk_vec('0,                 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00);

        // Reset held two cycles with busy inputs, then released.
        reset = 1'b1;
        apply_stimulus(make_load(3, 3), 1'b1);
        tick();
        tick();
        check_all_zero("reset_held");
        reset = 1'b0;
        apply_stimulus('0, 1'b0);
        #1;
        check_all_zero("reset_release");

        // Single R-type add x3 travels ID to WB in three edges.
        apply_stimulus(make_rtype(1, 2, 3), 1'b0);
        tick();
        check_output("add_ex_aluop", 32'(bus.ex_aluOp), 32'h2);
        apply_stimulus('0, 1'b0);
        tick();
        check_output("add_mem_wb_early", {31'b0, bus.wb_regWrite}, 32'h0);
        tick();
        check_output("add_wb", {25'b0, bus.wb_memToReg, bus.wb_regWrite, bus.wb_rd}, {25'b0, 1'b0, 1'b1, 5'd3});

        // Scoreboard stream of hazard-free instructions followed by a nop drain.
        for (int i = 0; i < 19; i++) begin
            instr_t ins;
            int     n;
            ins = (i < 16) ? random_instr() : instr_t'('0);
            apply_stimulus(ins, 1'($urandom_range(0, 1)));
            sb_q.push_back(ins);
            #1;
            check_output("sb_stall_pcsrc", {30'b0, bus.stall, bus.pcSrc}, 32'h0);
            tick();
            n = sb_q.size();
            check_output("sb_ex",
                {19'b0, bus.ex_aluOp, bus.ex_aluSrc, bus.ex_rs1, bus.ex_rs2},
                {19'b0, sb_q[n-1].alu_op, sb_q[n-1].alu_src, sb_q[n-1].rs1, sb_q[n-1].rs2});
            if (n >= 2) begin
                check_output("sb_mem",
                    {29'b0, bus.mem_memRead, bus.mem_memWrite, bus.mem_branch},
                    {29'b0, 1'b0, sb_q[n-2].mem_write, 1'b0});
            end
            if (n >= 3) begin
                check_output("sb_wb",
                    {25'b0, bus.wb_memToReg, bus.wb_regWrite, bus.wb_rd},
                    {25'b0, sb_q[0].mem_to_reg & sb_q[0].reg_write, sb_q[0].reg_write, sb_q[0].rd});
                void'(sb_q.pop_front());
            end
        end
        sb_q.delete();

        // Vector table: load-use stall, x0 load, forwarding priority and WB forwarding.
        for (int i = 0; i < 13; i++) begin
            apply_stimulus(vec[i].instr, vec[i].mem_zero);
            #1;
            check_output($sformatf("vec%0d_stall", i), {31'b0, bus.stall}, {31'b0, vec[i].exp_stall});
            check_output($sformatf("vec%0d_pcsrc_flush", i), {30'b0, bus.pcSrc, bus.flush},
                         {30'b0, vec[i].exp_pc_src, vec[i].exp_pc_src});
            check_output($sformatf("vec%0d_fwd", i), {28'b0, bus.forwardA, bus.forwardB},
                         {28'b0, vec[i].exp_fwd_a, vec[i].exp_fwd_b});
            tick();
            check_output($sformatf("vec%0d_ex_aluop", i), 32'(bus.ex_aluOp), 32'(vec[i].exp_ex_alu_op));
        end
        drain(3);

        // Not-taken beq: the following store is allowed to reach MEM.
        apply_stimulus(make_beq(1, 2), 1'b0);
        tick();
        apply_stimulus(make_store(2, 3), 1'b0);
        tick();
        apply_stimulus('0, 1'b0);
        #1;
        check_output("nt_pcsrc", {31'b0, bus.pcSrc}, 32'h0);
        tick();
        check_output("nt_store_mem", {31'b0, bus.mem_memWrite}, 32'h1);
        drain(3);

        // Taken beq: one-cycle flush, both younger instructions squashed.
        apply_stimulus(make_beq(1, 2), 1'b0);
        tick();
        apply_stimulus(make_store(2, 3), 1'b0);
        tick();
        apply_stimulus(make_rtype(4, 5, 6), 1'b1);
        #1;
        check_output("tk_pcsrc_flush_stall", {29'b0, bus.pcSrc, bus.flush, bus.stall}, 32'h6);
        tick();
        apply_stimulus('0, 1'b1);
        #1;
        check_output("tk_flush_one_cycle", {30'b0, bus.pcSrc, bus.flush}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            check_output($sformatf("tk_squash%0d", k), {30'b0, bus.mem_memWrite, bus.wb_regWrite}, 32'h0);
            tick();
        end
        drain(3);

        // Taken beq in MEM while ID holds a load-use consumer: flush wins.
        apply_stimulus(make_beq(1, 2), 1'b0);
        tick();
        apply_stimulus(make_load(1, 5), 1'b0);
        tick();
        apply_stimulus(make_rtype(5, 6, 7), 1'b1);
        #1;
        check_output("fs_flush_no_stall", {29'b0, bus.pcSrc, bus.flush, bus.stall}, 32'h6);
        tick();
        check_output("fs_killed", {29'b0, bus.ex_aluOp, bus.mem_memRead}, 32'h0);
        apply_stimulus(make_rtype(5, 6, 7), 1'b0);
        #1;
        check_output("fs_no_late_stall", {31'b0, bus.stall}, 32'h0);
        tick();
        drain(3);

        // Older and newer add x7 ahead of sub x7,x7, then a reset mid-flight.
        apply_stimulus(make_rtype(1, 2, 7), 1'b0);
        tick();
        apply_stimulus(make_rtype(3, 4, 7), 1'b0);
        tick();
        apply_stimulus(make_rtype(7, 7, 9), 1'b0);
        tick();
        apply_stimulus('0, 1'b0);
        #1;
        check_output("prio_fwd", {28'b0, bus.forwardA, bus.forwardB}, 32'hA);
        reset = 1'b1;
        apply_stimulus(make_load(7, 7), 1'b1);
        tick();
        check_all_zero("midreset");
        reset = 1'b0;
        apply_stimulus('0, 1'b0);
        tick();
        check_all_zero("after_midreset");

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
